// File: rtl/end_screen_overlay.sv
// end_screen_overlay
//   End-of-game banner overlay for the VGA pipeline. A small FSM latches the
//   game outcome (WIN/LOSE). While the outcome is held, a banner image is
//   fetched from an external two-bank ROM (bank 0 = WIN, bank 1 = LOSE) and
//   placed at (X0, Y0). The banner blinks every BLINK_FRAMES frames. ROM
//   pixels equal to KEY_COLOR are treated as transparent.
//
// Ports
//   i_clk          pixel clock
//   i_reset        synchronous, active-high reset
//   i_pix_row/col  current pixel coordinate from the timing generator
//   i_score_in     current score
//   i_crash_in     crash detected (level or pulse)
//   i_restart      one-cycle pulse that returns to play
//   o_rom_addr     {bank, row_off, col_off} to the external ROM
//   i_rom_data     ROM pixel {B,G,R}, ROM_LAT clocks after o_rom_addr
//   o_overlay_en   overlay pixel is opaque and replaces the background
//   o_overlay_out  overlay colour, 0 when o_overlay_en is low
//   o_win_flag     game-won state
//   o_lose_flag    game-lost state
//
// state  | meaning
// S_PLAY | race running, overlay off
// S_WIN  | score reached WIN_SCORE, WIN banner shown
// S_LOSE | crash seen, LOSE banner shown
module end_screen_overlay #(
    parameter int          IMG_W        = 128,
    parameter int          IMG_H        = 64,
    parameter int          X0           = 255,
    parameter int          Y0           = 207,
    parameter int          SCORE_W      = 6,
    parameter int          WIN_SCORE    = 50,
    parameter int          ROM_LAT      = 1,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] KEY_COLOR    = 12'h000,
    localparam int         CW           = $clog2(IMG_W),
    localparam int         RW           = $clog2(IMG_H),
    localparam int         AW           = 1 + CW + RW
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [9:0]         i_pix_row,
    input  logic [9:0]         i_pix_col,
    input  logic [SCORE_W-1:0] i_score_in,
    input  logic               i_crash_in,
    input  logic               i_restart,
    output logic [AW-1:0]      o_rom_addr,
    input  logic [11:0]        i_rom_data,
    output logic               o_overlay_en,
    output logic [11:0]        o_overlay_out,
    output logic               o_win_flag,
    output logic               o_lose_flag
);

    localparam logic [1:0] S_PLAY = 2'd0;
    localparam logic [1:0] S_WIN  = 2'd1;
    localparam logic [1:0] S_LOSE = 2'd2;

    // Box bounds in 11 bits so X0+IMG_W = 1024 does not wrap.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + IMG_W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + IMG_H);

    localparam int          BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_win_flag;
    logic               r_lose_flag;
    logic [BW-1:0]      r_blink_cnt;
    logic               r_visible;
    logic [AW-1:0]      r_rom_addr;
    logic [ROM_LAT:0]   r_sb;
    logic               r_overlay_en;
    logic [11:0]        r_overlay_out;

    logic               w_won;
    logic               w_active;
    logic               w_in_box;
    logic               w_frame_start;
    logic [CW-1:0]      w_col_off;
    logic [RW-1:0]      w_row_off;
    logic               w_bank;
    logic               w_hit;

    assign w_won         = (i_score_in >= SCORE_W'(WIN_SCORE));
    assign w_active      = (r_state != S_PLAY);
    assign w_bank        = (r_state == S_LOSE);
    assign w_frame_start = (i_pix_row == 10'd0) && (i_pix_col == 10'd0);
    assign w_in_box      = ({1'b0, i_pix_col} >= X_LO) && ({1'b0, i_pix_col} < X_HI) &&
                           ({1'b0, i_pix_row} >= Y_LO) && ({1'b0, i_pix_row} < Y_HI);
    // Truncated subtraction is exact inside the box; outside it the result is masked.
    assign w_col_off     = i_pix_col[CW-1:0] - CW'(X0);
    assign w_row_off     = i_pix_row[RW-1:0] - RW'(Y0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PLAY: begin
                if (w_won)
                    w_next = S_WIN;
                else if (i_crash_in)
                    w_next = S_LOSE;
            end
            S_WIN, S_LOSE: begin
                if (i_restart)
                    w_next = S_PLAY;
            end
            default: w_next = S_PLAY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_PLAY;
            r_win_flag  <= 1'b0;
            r_lose_flag <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_win_flag  <= (w_next == S_WIN);
            r_lose_flag <= (w_next == S_LOSE);
        end
    end

    // Blink phase is held at its start value in PLAY, so every entry into
    // WIN/LOSE begins with a visible banner and a fresh count.
    always_ff @(posedge i_clk) begin
        if (i_reset || (r_state == S_PLAY)) begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if (w_frame_start && (BLINK_FRAMES != 0)) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_visible   <= ~r_visible;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // r_sb[i] is the side-band (active & in_box & visible) for the pixel whose
    // ROM word arrives i clocks after its address; r_sb[ROM_LAT] lines up with i_rom_data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_addr    <= '0;
            r_sb          <= '0;
            r_overlay_en  <= 1'b0;
            r_overlay_out <= 12'h000;
        end else begin
            r_rom_addr    <= (w_active && w_in_box) ? {w_bank, w_row_off, w_col_off} : '0;
            r_sb          <= {r_sb[ROM_LAT-1:0], w_active & w_in_box & r_visible};
            r_overlay_en  <= w_hit;
            r_overlay_out <= w_hit ? i_rom_data : 12'h000;
        end
    end

    assign w_hit = r_sb[ROM_LAT] && (i_rom_data != KEY_COLOR);

    assign o_rom_addr    = r_rom_addr;
    assign o_overlay_en  = r_overlay_en;
    assign o_overlay_out = r_overlay_out;
    assign o_win_flag    = r_win_flag;
    assign o_lose_flag   = r_lose_flag;

endmodule

// File: tb/tb_end_screen_overlay.sv
module tb_end_screen_overlay;

    logic        clk;
    logic        reset;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;
    logic [5:0]  score_in;
    logic        crash_in;
    logic        restart;
    logic [13:0] rom_addr1, rom_addr3;
    logic [11:0] rom_data1, rom_data3;
    logic        en1, en3;
    logic [11:0] out1, out3;
    logic        win1, win3, lose1, lose3;
    logic [11:0] d3a, d3b;

    int total = 0;
    int bad   = 0;

    end_screen_overlay #(.ROM_LAT(1), .BLINK_FRAMES(2)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_pix_row(pix_row), .i_pix_col(pix_col),
        .i_score_in(score_in), .i_crash_in(crash_in), .i_restart(restart),
        .o_rom_addr(rom_addr1), .i_rom_data(rom_data1), .o_overlay_en(en1),
        .o_overlay_out(out1), .o_win_flag(win1), .o_lose_flag(lose1));

    end_screen_overlay #(.ROM_LAT(3), .BLINK_FRAMES(2)) dut3 (
        .i_clk(clk), .i_reset(reset), .i_pix_row(pix_row), .i_pix_col(pix_col),
        .i_score_in(score_in), .i_crash_in(crash_in), .i_restart(restart),
        .o_rom_addr(rom_addr3), .i_rom_data(rom_data3), .o_overlay_en(en3),
        .o_overlay_out(out3), .o_win_flag(win3), .o_lose_flag(lose3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM image: word = addr[11:0] ^ {bank, 11'h155}; column offsets ending in 3'd5 are transparent.
    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        return (a[2:0] == 3'd5) ? 12'h000 : (a[11:0] ^ {a[13], 11'h155});
    endfunction

    always_ff @(posedge clk) begin
        rom_data1 <= rom_fn(rom_addr1);
        d3a       <= rom_fn(rom_addr3);
        d3b       <= d3a;
        rom_data3 <= d3b;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pix_row = 10'd600;
        pix_col = 10'd900;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic w, input logic l);
        chk({tag, "_win1"}, {15'd0, win1}, {15'd0, w});
        chk({tag, "_lose1"}, {15'd0, lose1}, {15'd0, l});
        chk({tag, "_win3"}, {15'd0, win3}, {15'd0, w});
        chk({tag, "_lose3"}, {15'd0, lose3}, {15'd0, l});
    endtask

    // Present one pixel for one clock, then check the address, the ROM_LAT=1
    // overlay three clocks on and the ROM_LAT=3 overlay five clocks on.
    task automatic probe(input string tag, input logic [9:0] r, input logic [9:0] c,
                         input logic [13:0] ea, input logic ee, input logic [11:0] eo);
        pix_row = r;
        pix_col = c;
        tick();
        idle();
        chk({tag, "_addr1"}, {2'd0, rom_addr1}, {2'd0, ea});
        chk({tag, "_addr3"}, {2'd0, rom_addr3}, {2'd0, ea});
        tick();
        chk({tag, "_early_en1"}, {15'd0, en1}, 16'd0);
        tick();
        chk({tag, "_en1"}, {15'd0, en1}, {15'd0, ee});
        chk({tag, "_out1"}, {4'd0, out1}, {4'd0, eo});
        tick();
        chk({tag, "_early_en3"}, {15'd0, en3}, 16'd0);
        tick();
        chk({tag, "_en3"}, {15'd0, en3}, {15'd0, ee});
        chk({tag, "_out3"}, {4'd0, out3}, {4'd0, eo});
        tick();
    endtask

    task automatic frame_start();
        pix_row = 10'd0;
        pix_col = 10'd0;
        tick();
        idle();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        score_in = 6'd0;
        crash_in = 1'b0;
        restart  = 1'b0;
        idle();
        repeat (4) tick();
        chk_flags("reset", 1'b0, 1'b0);
        chk("reset_addr1", {2'd0, rom_addr1}, 16'd0);
        chk("reset_en1", {15'd0, en1}, 16'd0);
        chk("reset_out3", {4'd0, out3}, 16'd0);
        reset = 1'b0;
        tick();

        // Play: nothing shown, address held at 0, even inside the box.
        probe("play_corner", 10'd207, 10'd255, 14'h0000, 1'b0, 12'h000);
        probe("play_mid", 10'd240, 10'd300, 14'h0000, 1'b0, 12'h000);
        probe("play_far", 10'd270, 10'd382, 14'h0000, 1'b0, 12'h000);
        score_in = 6'd49;
        tick();
        chk_flags("score49", 1'b0, 1'b0);

        // Win at threshold; flag rises on the next edge.
        score_in = 6'd50;
        tick();
        score_in = 6'd0;
        chk_flags("win_rise", 1'b1, 1'b0);
        probe("win_corner", 10'd207, 10'd255, 14'h0000, 1'b1, 12'h155);
        probe("win_far", 10'd270, 10'd382, 14'h1FFF, 1'b1, 12'hEAA);
        crash_in = 1'b1;
        tick();
        crash_in = 1'b0;
        chk_flags("win_ignore_crash", 1'b1, 1'b0);
        pulse_restart();
        chk_flags("win_restart", 1'b0, 1'b0);

        // Win beats crash in the same cycle.
        crash_in = 1'b1;
        score_in = 6'd50;
        tick();
        crash_in = 1'b0;
        score_in = 6'd0;
        chk_flags("win_prio", 1'b1, 1'b0);
        pulse_restart();

        // Lose on crash alone, bank 1.
        crash_in = 1'b1;
        tick();
        crash_in = 1'b0;
        chk_flags("lose_rise", 1'b0, 1'b1);
        probe("lose_corner", 10'd207, 10'd255, 14'h2000, 1'b1, 12'h955);
        probe("lose_far", 10'd270, 10'd382, 14'h3FFF, 1'b1, 12'h6AA);
        probe("edge_above", 10'd206, 10'd255, 14'h0000, 1'b0, 12'h000);
        probe("edge_left", 10'd207, 10'd254, 14'h0000, 1'b0, 12'h000);
        probe("edge_below", 10'd271, 10'd255, 14'h0000, 1'b0, 12'h000);
        probe("edge_right", 10'd207, 10'd383, 14'h0000, 1'b0, 12'h000);
        pulse_restart();
        chk_flags("lose_restart", 1'b0, 1'b0);
        pulse_restart();
        chk_flags("play_restart", 1'b0, 1'b0);

        // Blink with BLINK_FRAMES=2: frames 0-1 shown, 2-3 hidden, 4-5 shown.
        score_in = 6'd50;
        tick();
        score_in = 6'd0;
        probe("blink_f0", 10'd207, 10'd256, 14'h0001, 1'b1, 12'h154);
        probe("key_f0", 10'd207, 10'd260, 14'h0005, 1'b0, 12'h000);
        frame_start();
        probe("blink_f1", 10'd207, 10'd256, 14'h0001, 1'b1, 12'h154);
        frame_start();
        probe("blink_f2", 10'd207, 10'd256, 14'h0001, 1'b0, 12'h000);
        frame_start();
        probe("blink_f3", 10'd207, 10'd256, 14'h0001, 1'b0, 12'h000);
        frame_start();
        probe("blink_f4", 10'd207, 10'd256, 14'h0001, 1'b1, 12'h154);
        probe("key_f4", 10'd207, 10'd260, 14'h0005, 1'b0, 12'h000);
        frame_start();
        frame_start();
        probe("blink_f6", 10'd207, 10'd256, 14'h0001, 1'b0, 12'h000);

        // Reset with a visible pixel in flight clears everything next edge.
        frame_start();
        frame_start();
        pix_row = 10'd207;
        pix_col = 10'd256;
        tick();
        idle();
        chk("inflight_addr1", {2'd0, rom_addr1}, 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_flags("midreset", 1'b0, 1'b0);
        chk("midreset_addr1", {2'd0, rom_addr1}, 16'd0);
        chk("midreset_en1", {15'd0, en1}, 16'd0);
        tick();
        chk("midreset_en1_late", {15'd0, en1}, 16'd0);
        tick();
        tick();
        chk("midreset_en3_late", {15'd0, en3}, 16'd0);
        probe("after_reset_play", 10'd207, 10'd256, 14'h0000, 1'b0, 12'h000);
        score_in = 6'd63;
        tick();
        score_in = 6'd0;
        chk_flags("rewin", 1'b1, 1'b0);
        probe("rewin_visible", 10'd207, 10'd256, 14'h0001, 1'b1, 12'h154);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
